// File: rtl/aes_response_collector.sv
// ---------------------------------------------------------------------------
// AesResponseCollector (module aes_response_collector)
//
// Response path of the AES emulation bench. Encoder and decoder result
// strobes are tagged with a per-source sequence number and buffered in two
// independent FIFOs. A small FSM turns each buffered result into a 5-word
// frame on a valid/ready stream:
//   word0 = {8'hA5, 7'b0, tag, seq}   (tag 0 = encoder, 1 = decoder)
//   word1..word4 = data[127:96], [95:64], [63:32], [31:0]
// A flush request drains every pending result and then emits a single
// end-of-message word {8'h5A, 8'h00, framesSent}.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   i_encData/i_encValid  encoder result and its strobe
//   i_decData/i_decValid  decoder result and its strobe
//   i_flush             single-cycle end-of-message request
//   o_outData/o_outValid/i_outReady/o_outLast  output word stream
//   o_overflow          sticky: a result was dropped on a full FIFO
//   o_flushDone         one-cycle pulse after the EOM word is accepted
//   o_busy              high while any work is pending or in flight
// ---------------------------------------------------------------------------
module aes_response_collector #(
  parameter int FIFO_DEPTH = 8,
  parameter int SEQ_W      = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] i_encData,
  input  logic         i_encValid,
  input  logic [127:0] i_decData,
  input  logic         i_decValid,
  input  logic         i_flush,
  output logic [31:0]  o_outData,
  output logic         o_outValid,
  input  logic         i_outReady,
  output logic         o_outLast,
  output logic         o_overflow,
  output logic         o_flushDone,
  output logic         o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = SEQ_W + 128;

  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [SEQ_W-1:0] SEQ_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_EOM
  } state_t;

  // FIFO storage: each entry is {seq, data}
  logic [EW-1:0] r_encMem [FIFO_DEPTH];
  logic [EW-1:0] r_decMem [FIFO_DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart
  logic [AW:0]      r_encWr;
  logic [AW:0]      r_encRd;
  logic [AW:0]      r_decWr;
  logic [AW:0]      r_decRd;
  logic [SEQ_W-1:0] r_encSeq;
  logic [SEQ_W-1:0] r_decSeq;

  state_t           r_state;
  logic             r_sel;
  logic             r_ptr;
  logic [1:0]       r_idx;
  logic [SEQ_W-1:0] r_framesSent;
  logic             r_flushPending;

  logic          w_encEmpty;
  logic          w_decEmpty;
  logic          w_encFull;
  logic          w_decFull;
  logic [EW-1:0] w_encHead;
  logic [EW-1:0] w_decHead;
  logic          w_lastAccept;
  logic          w_encPop;
  logic          w_decPop;
  logic          w_encPush;
  logic          w_decPush;
  logic          w_encDrop;
  logic          w_decDrop;
  logic          w_selDec;
  logic [EW-1:0] w_selHead;
  logic [127:0]  w_curData;
  logic [31:0]   w_hdrWord;
  logic [31:0]   w_eomWord;

  // Pick one 32-bit slice of a result, most significant word first
  function automatic logic [31:0] dataWord(input logic [127:0] d, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = d[127:96];
      2'd1:    w = d[95:64];
      2'd2:    w = d[63:32];
      default: w = d[31:0];
    endcase
    return w;
  endfunction

  // FIFO status derived from the pointer pairs
  assign w_encEmpty = (r_encWr == r_encRd);
  assign w_decEmpty = (r_decWr == r_decRd);
  assign w_encFull  = (r_encWr[AW] != r_encRd[AW]) && (r_encWr[AW-1:0] == r_encRd[AW-1:0]);
  assign w_decFull  = (r_decWr[AW] != r_decRd[AW]) && (r_decWr[AW-1:0] == r_decRd[AW-1:0]);
  assign w_encHead  = r_encMem[r_encRd[AW-1:0]];
  assign w_decHead  = r_decMem[r_decRd[AW-1:0]];

  // The head entry is popped only when the final data word is accepted
  assign w_lastAccept = (r_state == S_DATA) && (r_idx == 2'd3) && i_outReady;
  assign w_encPop     = w_lastAccept && !r_sel;
  assign w_decPop     = w_lastAccept &&  r_sel;

  // A push into a full FIFO still succeeds when the head leaves the same cycle;
  // everything is ignored (no drop, no overflow) while a flush is pending
  assign w_encPush = i_encValid && !r_flushPending && (!w_encFull || w_encPop);
  assign w_decPush = i_decValid && !r_flushPending && (!w_decFull || w_decPop);
  assign w_encDrop = i_encValid && !r_flushPending &&  w_encFull && !w_encPop;
  assign w_decDrop = i_decValid && !r_flushPending &&  w_decFull && !w_decPop;

  // Source selection in IDLE: the lone non-empty side wins, otherwise the pointer decides
  assign w_selDec  = w_encEmpty ? 1'b1 : (w_decEmpty ? 1'b0 : r_ptr);
  assign w_selHead = w_selDec ? w_decHead : w_encHead;
  assign w_curData = r_sel ? w_decHead[127:0] : w_encHead[127:0];
  assign w_hdrWord = {8'hA5, 7'b0, w_selDec, 16'(w_selHead[EW-1:128])};
  assign w_eomWord = {8'h5A, 8'h00, 16'(r_framesSent)};

  assign o_busy = (r_state != S_IDLE) | ~w_encEmpty | ~w_decEmpty | r_flushPending;

  // Entry storage is written without reset; validity lives in the pointers
  always_ff @(posedge clock) begin
    if (w_encPush) r_encMem[r_encWr[AW-1:0]] <= {r_encSeq, i_encData};
    if (w_decPush) r_decMem[r_decWr[AW-1:0]] <= {r_decSeq, i_decData};
  end

  // Encoder FIFO pointers and sequence counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_encWr  <= '0;
      r_encRd  <= '0;
      r_encSeq <= '0;
    end else begin
      if (w_encPush) begin
        r_encWr  <= r_encWr + PTR_ONE;
        r_encSeq <= r_encSeq + SEQ_ONE;
      end
      if (w_encPop) r_encRd <= r_encRd + PTR_ONE;
    end
  end

  // Decoder FIFO pointers and sequence counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_decWr  <= '0;
      r_decRd  <= '0;
      r_decSeq <= '0;
    end else begin
      if (w_decPush) begin
        r_decWr  <= r_decWr + PTR_ONE;
        r_decSeq <= r_decSeq + SEQ_ONE;
      end
      if (w_decPop) r_decRd <= r_decRd + PTR_ONE;
    end
  end

  // Sticky drop indicator
  always_ff @(posedge clock) begin
    if (reset) begin
      o_overflow <= 1'b0;
    end else if (w_encDrop || w_decDrop) begin
      o_overflow <= 1'b1;
    end
  end

  // Frame serialiser with registered stream outputs. Each word is loaded one
  // edge ahead, so out_data/out_last only change on an accept or state entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_sel          <= 1'b0;
      r_ptr          <= 1'b0;
      r_idx          <= 2'd0;
      r_framesSent   <= '0;
      r_flushPending <= 1'b0;
      o_outData      <= '0;
      o_outValid     <= 1'b0;
      o_outLast      <= 1'b0;
      o_flushDone    <= 1'b0;
    end else begin
      o_flushDone <= 1'b0;
      if (i_flush && !r_flushPending) r_flushPending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          // Pending results always go out before the end-of-message word
          if (!w_encEmpty || !w_decEmpty) begin
            r_state    <= S_HDR;
            r_sel      <= w_selDec;
            r_ptr      <= ~r_ptr;
            o_outValid <= 1'b1;
            o_outData  <= w_hdrWord;
            o_outLast  <= 1'b0;
          end else if (r_flushPending) begin
            r_state    <= S_EOM;
            o_outValid <= 1'b1;
            o_outData  <= w_eomWord;
            o_outLast  <= 1'b1;
          end
        end

        S_HDR: begin
          if (i_outReady) begin
            r_state   <= S_DATA;
            r_idx     <= 2'd0;
            o_outData <= dataWord(w_curData, 2'd0);
            o_outLast <= 1'b0;
          end
        end

        S_DATA: begin
          if (i_outReady) begin
            if (r_idx == 2'd3) begin
              r_state      <= S_IDLE;
              r_framesSent <= r_framesSent + SEQ_ONE;
              o_outValid   <= 1'b0;
              o_outData    <= '0;
              o_outLast    <= 1'b0;
            end else begin
              r_idx     <= r_idx + 2'd1;
              o_outData <= dataWord(w_curData, r_idx + 2'd1);
              o_outLast <= (r_idx == 2'd2);
            end
          end
        end

        S_EOM: begin
          if (i_outReady) begin
            r_state        <= S_IDLE;
            r_flushPending <= 1'b0;
            r_framesSent   <= '0;
            o_flushDone    <= 1'b1;
            o_outValid     <= 1'b0;
            o_outData      <= '0;
            o_outLast      <= 1'b0;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          o_outValid <= 1'b0;
          o_outLast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_response_collector.sv
// ---------------------------------------------------------------------------
// tb_aes_response_collector
//
// Directed, self-checking bench for aes_response_collector. Accepted stream
// words are captured into a queue by a negedge monitor, which also checks
// that a stalled word holds steady. Frames are compared against expected
// headers and payloads written out by hand.
// ---------------------------------------------------------------------------
module tb_aes_response_collector;

  logic         clock;
  logic         reset;
  logic [127:0] i_encData;
  logic         i_encValid;
  logic [127:0] i_decData;
  logic         i_decValid;
  logic         i_flush;
  logic [31:0]  o_outData;
  logic         o_outValid;
  logic         i_outReady;
  logic         o_outLast;
  logic         o_overflow;
  logic         o_flushDone;
  logic         o_busy;

  int checks = 0;
  int errors = 0;
  int fdCount = 0;

  logic [32:0] capQ[$];
  logic        prevStall = 1'b0;
  logic [32:0] prevWord = '0;

  typedef struct {
    bit           encV;
    logic [127:0] encD;
    bit           decV;
    logic [127:0] decD;
  } pushVec_t;

  typedef struct {
    logic [31:0]  hdr;
    logic [127:0] data;
  } frameExp_t;

  pushVec_t  pushTab[4];
  frameExp_t expTab[7];

  aes_response_collector #(.FIFO_DEPTH(8), .SEQ_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .i_encData  (i_encData),
    .i_encValid (i_encValid),
    .i_decData  (i_decData),
    .i_decValid (i_decValid),
    .i_flush    (i_flush),
    .o_outData  (o_outData),
    .o_outValid (o_outValid),
    .i_outReady (i_outReady),
    .o_outLast  (o_outLast),
    .o_overflow (o_overflow),
    .o_flushDone(o_flushDone),
    .o_busy     (o_busy)
  );

  // 10-unit clock period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run can never hang
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Capture accepted words and verify stalled words do not change
  always @(negedge clock) begin
    if (reset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) check("stallHold", {o_outValid, o_outLast, o_outData}, {1'b1, prevWord});
      if (o_outValid && i_outReady) capQ.push_back({o_outLast, o_outData});
      if (o_flushDone) fdCount++;
      prevStall = o_outValid && !i_outReady;
      prevWord  = {o_outLast, o_outData};
    end
  end

  task automatic doReset();
    reset      = 1'b1;
    i_encValid = 1'b0;
    i_decValid = 1'b0;
    i_encData  = '0;
    i_decData  = '0;
    i_flush    = 1'b0;
    i_outReady = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    capQ.delete();
    fdCount = 0;
  endtask

  task automatic waitWords(input int n, input string name);
    int c = 0;
    while (capQ.size() < n && c < 400) begin
      cycle();
      c++;
    end
    if (capQ.size() < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: timeout, got %0d words, expected %0d", name, capQ.size(), n);
    end
  endtask

  task automatic checkFrame(input string name, input logic [31:0] hdr, input logic [127:0] data);
    logic [32:0] got;
    logic [32:0] exp;
    waitWords(5, name);
    if (capQ.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        got = capQ.pop_front();
        case (k)
          0:       exp = {1'b0, hdr};
          1:       exp = {1'b0, data[127:96]};
          2:       exp = {1'b0, data[95:64]};
          3:       exp = {1'b0, data[63:32]};
          default: exp = {1'b1, data[31:0]};
        endcase
        check($sformatf("%s word%0d", name, k), 64'(got), 64'(exp));
      end
    end
  endtask

  task automatic applyStimulus(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      i_encValid = pushTab[r].encV;
      i_encData  = pushTab[r].encD;
      i_decValid = pushTab[r].decV;
      i_decData  = pushTab[r].decD;
      cycle();
    end
    i_encValid = 1'b0;
    i_decValid = 1'b0;
  endtask

  task automatic checkOutput(input int first, input int last);
    for (int f = first; f <= last; f++) begin
      checkFrame($sformatf("frame%0d", f), expTab[f].hdr, expTab[f].data);
    end
  endtask

  initial begin
    pushTab[0] = '{1'b1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 128'h0};
    pushTab[1] = '{1'b1, 128'h10000000_10000001_10000002_10000003,
                   1'b1, 128'h20000000_20000001_20000002_20000003};
    pushTab[2] = '{1'b1, 128'h11111111_11111112_11111113_11111114,
                   1'b1, 128'h22222221_22222222_22222223_22222224};
    pushTab[3] = '{1'b1, 128'h3333AAAA_3333BBBB_3333CCCC_3333DDDD,
                   1'b1, 128'h4444AAAA_4444BBBB_4444CCCC_4444DDDD};

    expTab[0] = '{32'hA5000000, 128'h00112233_44556677_8899AABB_CCDDEEFF};
    expTab[1] = '{32'hA5000000, 128'h10000000_10000001_10000002_10000003};
    expTab[2] = '{32'hA5010000, 128'h20000000_20000001_20000002_20000003};
    expTab[3] = '{32'hA5000001, 128'h11111111_11111112_11111113_11111114};
    expTab[4] = '{32'hA5010001, 128'h22222221_22222222_22222223_22222224};
    expTab[5] = '{32'hA5000002, 128'h3333AAAA_3333BBBB_3333CCCC_3333DDDD};
    expTab[6] = '{32'hA5010002, 128'h4444AAAA_4444BBBB_4444CCCC_4444DDDD};

    // Reset state
    doReset();
    check("rstValid", 64'(o_outValid), 64'h0);
    check("rstData", 64'(o_outData), 64'h0);
    check("rstLast", 64'(o_outLast), 64'h0);
    check("rstOverflow", 64'(o_overflow), 64'h0);
    check("rstFlushDone", 64'(o_flushDone), 64'h0);
    check("rstBusy", 64'(o_busy), 64'h0);

    // Test 1: single encode, including header latency
    $display("[TB] test 1: single encode");
    i_outReady = 1'b1;
    applyStimulus(0, 0);
    check("t1ValidBeforeHdr", 64'(o_outValid), 64'h0);
    cycle();
    check("t1HdrValid", 64'({o_outValid, o_outData}), 64'({1'b1, 32'hA5000000}));
    checkOutput(0, 0);
    check("t1Overflow", 64'(o_overflow), 64'h0);

    // Test 2: simultaneous pushes alternate enc/dec
    $display("[TB] test 2: interleaved enc/dec");
    doReset();
    i_outReady = 1'b1;
    applyStimulus(1, 3);
    checkOutput(1, 6);

    // Test 3: backpressure with ready toggling every cycle
    $display("[TB] test 3: backpressure");
    doReset();
    i_decValid = 1'b1;
    i_decData  = 128'hDEAD0001_DEAD0002_DEAD0003_DEAD0004;
    cycle();
    i_decData  = 128'hBEEF0001_BEEF0002_BEEF0003_BEEF0004;
    cycle();
    i_decValid = 1'b0;
    for (int c = 0; c < 200 && capQ.size() < 10; c++) begin
      i_outReady = ~i_outReady;
      cycle();
    end
    checkFrame("t3f0", 32'hA5010000, 128'hDEAD0001_DEAD0002_DEAD0003_DEAD0004);
    checkFrame("t3f1", 32'hA5010001, 128'hBEEF0001_BEEF0002_BEEF0003_BEEF0004);
    i_outReady = 1'b1;
    cycle();
    cycle();
    check("t3BusyAfter", 64'(o_busy), 64'h0);

    // Test 4: overflow on the 9th push while stalled
    $display("[TB] test 4: overflow");
    doReset();
    for (int k = 0; k < 10; k++) begin
      i_encValid = 1'b1;
      i_encData  = {4{32'hC0000000 | 32'(k)}};
      cycle();
      check($sformatf("t4Overflow%0d", k), 64'(o_overflow), 64'((k >= 8) ? 1 : 0));
    end
    i_encValid = 1'b0;
    check("t4StalledHdr", 64'({o_outValid, o_busy, o_outData}), 64'({1'b1, 1'b1, 32'hA5000000}));
    i_outReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checkFrame($sformatf("t4f%0d", k), 32'hA5000000 | 32'(k), {4{32'hC0000000 | 32'(k)}});
    end
    i_encValid = 1'b1;
    i_encData  = {4{32'hCAFE0008}};
    cycle();
    i_encValid = 1'b0;
    checkFrame("t4seq8", 32'hA5000008, {4{32'hCAFE0008}});

    // Test 5: flush together with a push, drain, then EOM
    $display("[TB] test 5: flush");
    doReset();
    i_encValid = 1'b1;
    i_encData  = 128'hE5E5E5E5_00000001_00000002_00000003;
    i_decValid = 1'b1;
    i_decData  = 128'hD5D5D5D5_00000004_00000005_00000006;
    i_flush    = 1'b1;
    cycle();
    i_flush    = 1'b0;
    i_decValid = 1'b0;
    i_encData  = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    cycle();
    cycle();
    cycle();
    i_encValid = 1'b0;
    check("t5Busy", 64'(o_busy), 64'h1);
    check("t5Overflow", 64'(o_overflow), 64'h0);
    i_outReady = 1'b1;
    checkFrame("t5enc", 32'hA5000000, 128'hE5E5E5E5_00000001_00000002_00000003);
    checkFrame("t5dec", 32'hA5010000, 128'hD5D5D5D5_00000004_00000005_00000006);
    waitWords(1, "t5eom");
    if (capQ.size() >= 1) check("t5EomWord", 64'(capQ.pop_front()), 64'({1'b1, 32'h5A000002}));
    check("t5FlushDoneHigh", 64'(o_flushDone), 64'h1);
    cycle();
    check("t5FlushDoneLow", 64'(o_flushDone), 64'h0);
    check("t5BusyAfter", 64'(o_busy), 64'h0);
    for (int c = 0; c < 8; c++) cycle();
    check("t5NoExtraWords", 64'(capQ.size()), 64'h0);
    check("t5PulseCount", 64'(fdCount), 64'h1);

    // Test 6: reset in the middle of a frame
    $display("[TB] test 6: reset mid-frame");
    doReset();
    for (int k = 0; k < 9; k++) begin
      i_encValid = 1'b1;
      i_encData  = {4{32'h60000000 | 32'(k)}};
      cycle();
    end
    i_encValid = 1'b0;
    check("t6OverflowSet", 64'(o_overflow), 64'h1);
    i_outReady = 1'b1;
    waitWords(3, "t6words");
    reset = 1'b1;
    cycle();
    check("t6RstValid", 64'(o_outValid), 64'h0);
    check("t6RstBusy", 64'(o_busy), 64'h0);
    check("t6RstOverflow", 64'(o_overflow), 64'h0);
    reset = 1'b0;
    capQ.delete();
    i_encValid = 1'b1;
    i_encData  = 128'hF00DF00D_12345678_9ABCDEF0_0F0F0F0F;
    cycle();
    i_encValid = 1'b0;
    checkFrame("t6seq0", 32'hA5000000, 128'hF00DF00D_12345678_9ABCDEF0_0F0F0F0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
